// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one request, checks alignment and range, runs a
// single-cycle memory access and returns a one-cycle response with debug counters.
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 2048,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [31:0]      resp_rdata,
  output logic             MemR,
  output logic             MemWr,
  output logic [1:0]       MemWrBits,
  output logic [2:0]       MemRBits,
  output logic [31:0]      MemAddr,
  output logic [31:0]      MemWData,
  input  logic [31:0]      MemRData,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e           state_q, state_d;
  logic             store_q, store_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] cntLoad_q, cntLoad_d;
  logic [CNT_W-1:0] cntStore_q, cntStore_d;
  logic [CNT_W-1:0] cntErr_q, cntErr_d;
  logic             reqErr;
  logic [2:0]       readCode;

  always_comb begin
    reqErr = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b00 && req_addr[1:0] != 2'b00)
           || (req_addr >= 32'(MEM_BYTES));
  end

  // Memory read code: the memory does lane selection and extension itself.
  always_comb begin
    readCode = 3'b000;
    case (size_q)
      2'b01:   readCode = uns_q ? 3'b001 : 3'b010;
      2'b10:   readCode = uns_q ? 3'b011 : 3'b100;
      default: readCode = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    size_d     = size_q;
    uns_d      = uns_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    cntLoad_d  = cntLoad_q;
    cntStore_d = cntStore_q;
    cntErr_d   = cntErr_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    MemR       = 1'b0;
    MemWr      = 1'b0;
    MemWrBits  = 2'b00;
    MemRBits   = 3'b000;
    MemAddr    = 32'h0;
    MemWData   = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (reqErr) begin
            err_d    = 1'b1;
            rdata_d  = 32'h0;
            cntErr_d = cntErr_q + CNT_W'(1);
            state_d  = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // Strobes are gated by rst so a store racing a reset never writes.
        MemAddr = addr_q;
        if (store_q) begin
          MemWr      = ~rst;
          MemWrBits  = size_q;
          MemWData   = wdata_q;
          rdata_d    = 32'h0;
          cntStore_d = cntStore_q + CNT_W'(1);
        end else begin
          MemR      = ~rst;
          MemRBits  = readCode;
          rdata_d   = MemRData;
          cntLoad_d = cntLoad_q + CNT_W'(1);
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      cntLoad_q  <= '0;
      cntStore_q <= '0;
      cntErr_q   <= '0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      cntLoad_q  <= cntLoad_d;
      cntStore_q <= cntStore_d;
      cntErr_q   <= cntErr_d;
    end
  end

  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  assign cnt_load   = cntLoad_q;
  assign cnt_store  = cntStore_q;
  assign cnt_err    = cntErr_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: a word-organised memory device plus a byte-level
// reference model that predicts every response, its timing and its memory strobe.
module tb_lsu_ctrl;
  localparam int MEM_BYTES = 2048;
  localparam int CNT_W     = 16;

  logic             clk, rst;
  logic             req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]       req_size;
  logic [31:0]      req_addr, req_wdata;
  logic             resp_valid, resp_err;
  logic [31:0]      resp_rdata;
  logic             MemR, MemWr;
  logic [1:0]       MemWrBits;
  logic [2:0]       MemRBits;
  logic [31:0]      MemAddr, MemWData, MemRData;
  logic [CNT_W-1:0] cnt_load, cnt_store, cnt_err;

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .MemR(MemR), .MemWr(MemWr), .MemWrBits(MemWrBits),
    .MemRBits(MemRBits), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .cnt_load(cnt_load), .cnt_store(cnt_store),
    .cnt_err(cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Memory device: 512 words, little-endian lanes, extension driven by MemRBits.
  logic [31:0] devMem [512];
  logic [8:0]  devIdx;
  logic [31:0] devWord;
  logic [15:0] devHalf;
  logic [7:0]  devByte;
  assign devIdx = MemAddr[10:2];

  always @(posedge clk) begin
    if (MemWr) begin
      case (MemWrBits)
        2'b00: devMem[devIdx] <= MemWData;
        2'b01: devMem[devIdx][{MemAddr[1], 4'b0} +: 16] <= MemWData[15:0];
        2'b10: devMem[devIdx][{MemAddr[1:0], 3'b0} +: 8] <= MemWData[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    devWord  = devMem[devIdx];
    devHalf  = devWord[{MemAddr[1], 4'b0} +: 16];
    devByte  = devWord[{MemAddr[1:0], 3'b0} +: 8];
    MemRData = 32'h0;
    case (MemRBits)
      3'b000:  MemRData = devWord;
      3'b001:  MemRData = {16'h0, devHalf};
      3'b010:  MemRData = {{16{devHalf[15]}}, devHalf};
      3'b011:  MemRData = {24'h0, devByte};
      3'b100:  MemRData = {{24{devByte[7]}}, devByte};
      default: MemRData = 32'h0;
    endcase
  end

  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] rdata;
    int          kind;
    logic [31:0] addr;
    int          bits;
    logic [31:0] wdata;
  } exp_t;

  exp_t        expQ[$];
  logic [7:0]  refMem [MEM_BYTES];
  int          refLoad = 0, refStore = 0, refErr = 0;
  int          lastAccept = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: byte array, alignment as a divisibility rule, extension by arithmetic.
  task automatic model(input bit st, input logic [1:0] sz, input bit un,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int n;
    longint v;
    n = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    e.err   = (sz == 2'b11) || (a % n != 0) || (a >= 32'(MEM_BYTES));
    e.rdata = 32'h0;
    e.kind  = 0;
    e.addr  = a;
    e.bits  = 0;
    e.wdata = wd;
    if (e.err) begin
      refErr++;
    end else if (st) begin
      for (int i = 0; i < n; i++) refMem[int'(a) + i] = wd[8*i +: 8];
      e.kind = 2;
      e.bits = int'(sz);
      refStore++;
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (longint'(refMem[int'(a) + i]) << (8 * i));
      if (!un && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
      e.rdata = v[31:0];
      e.kind  = 1;
      e.bits  = (n == 4) ? 0 : (n == 2) ? (un ? 1 : 2) : (un ? 3 : 4);
      refLoad++;
    end
  endtask

  // Monitor: records memory strobes and pops the scoreboard on each response.
  int          strobes = 0;
  int          sKind = 0, sBits = 0;
  logic [31:0] sAddr = 0, sWdata = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      strobes = 0;
    end else begin
      if (MemR || MemWr) begin
        strobes++;
        sKind  = MemWr ? 2 : 1;
        sBits  = MemWr ? int'(MemWrBits) : int'(MemRBits);
        sAddr  = MemAddr;
        sWdata = MemWData;
        checkOutput("strobe_exclusive", 32'(MemR & MemWr), 32'h0);
      end
      if (resp_valid) begin
        checkOutput("ready_in_resp", 32'(req_ready), 32'h0);
        checkOutput("memaddr_idle", MemAddr, 32'h0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected_resp", 32'(resp_valid), 32'h0);
        end else begin
          e = expQ.pop_front();
          checkOutput("resp_cycle", 32'(cyc), 32'(e.cyc));
          checkOutput("resp_err", 32'(resp_err), 32'(e.err));
          checkOutput("resp_rdata", resp_rdata, e.rdata);
          checkOutput("strobe_count", 32'(strobes), (e.kind != 0) ? 32'd1 : 32'd0);
          if (e.kind != 0 && strobes == 1) begin
            checkOutput("strobe_kind", 32'(sKind), 32'(e.kind));
            checkOutput("strobe_addr", sAddr, e.addr);
            checkOutput("strobe_bits", 32'(sBits), 32'(e.bits));
            if (e.kind == 2) checkOutput("strobe_wdata", sWdata, e.wdata);
          end
        end
        strobes = 0;
      end
    end
  end

  task automatic drivePoint();
    @(negedge clk);
    #1;
  endtask

  // Presents a request and leaves req_valid high; returns one cycle after acceptance.
  task automatic applyStimulus(input bit st, input logic [1:0] sz, input bit un,
                               input logic [31:0] a, input logic [31:0] wd,
                               input bit track = 1'b1);
    exp_t e;
    int waitCnt;
    req_valid = 1'b1; req_store = st; req_size = sz;
    req_unsigned = un; req_addr = a; req_wdata = wd;
    waitCnt = 0;
    while (!req_ready && waitCnt < 20) begin
      drivePoint();
      waitCnt++;
    end
    if (!req_ready) begin
      checkOutput("accept_timeout", 32'(req_ready), 32'h1);
      return;
    end
    lastAccept = cyc + 1;
    if (track) begin
      model(st, sz, un, a, wd, e);
      e.cyc = cyc + (e.err ? 1 : 2);
      expQ.push_back(e);
    end
    drivePoint();
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      drivePoint();
      n++;
    end
    checkOutput("drain_empty", 32'(expQ.size()), 32'h0);
    drivePoint();
    drivePoint();
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_cnt_load"},  32'(cnt_load),  32'(refLoad  % (1 << CNT_W)));
    checkOutput({tag, "_cnt_store"}, 32'(cnt_store), 32'(refStore % (1 << CNT_W)));
    checkOutput({tag, "_cnt_err"},   32'(cnt_err),   32'(refErr   % (1 << CNT_W)));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int prevAccept;
    logic [1:0]  sz;
    logic [31:0] a;
    for (int i = 0; i < 512; i++) devMem[i] = 32'h0;
    for (int i = 0; i < MEM_BYTES; i++) refMem[i] = 8'h0;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) drivePoint();
    rst = 1'b0;
    drivePoint();

    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_mem_strobes", {30'h0, MemR, MemWr}, 32'h0);
    checkOutput("rst_mem_addr", MemAddr, 32'h0);
    checkCounters("rst");

    applyStimulus(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    drain();
    checkCounters("word");

    applyStimulus(1'b1, 2'b10, 1'b0, 32'h23, 32'hAAAAAA80);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h23, 32'h0);
    applyStimulus(1'b0, 2'b10, 1'b1, 32'h23, 32'h0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h22, 32'h55558001);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    drain();

    applyStimulus(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h21, 32'h1234);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h800, 32'h0);
    applyStimulus(1'b0, 2'b11, 1'b0, 32'h30, 32'h0);
    drain();
    checkCounters("errors");

    // req_valid held high across consecutive valid requests.
    prevAccept = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i[0] ? 1'b0 : 1'b1, 2'b00, 1'b0, 32'h100 + 32'(4 * (i / 2)), $urandom);
      if (i > 0) checkOutput("accept_spacing", 32'(lastAccept - prevAccept), 32'd3);
      prevAccept = lastAccept;
    end
    drain();

    for (int i = 0; i < 80; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 2150));
      if ($urandom_range(0, 9) < 7) a = (sz == 2'b00) ? (a & ~32'h3) : (sz == 2'b01) ? (a & ~32'h1) : a;
      applyStimulus(1'($urandom), sz, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) drivePoint();
      end
    end
    drain();
    checkCounters("random");

    // Reset lands on the ACCESS cycle of an untracked store to 0x40.
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h40, 32'hC0FFEE11, 1'b0);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_access_memwr", 32'(MemWr), 32'h0);
    drivePoint();
    rst = 1'b0;
    refLoad = 0; refStore = 0; refErr = 0;
    checkOutput("rst_access_ready", 32'(req_ready), 32'h1);
    checkCounters("rst_access");
    repeat (4) drivePoint();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
    drain();
    checkCounters("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the multi-cycle CPU datapath and the data memory. It accepts one load or store request per handshake and checks alignment and address range. For valid requests it drives a single-cycle memory access using the data memory's strobe and size-code interface, then returns a one-cycle response with load data or an error flag. It also keeps per-type access counters for debug.

## Interface
- MEM_BYTES, 2048 — byte size of data memory (512 words); addresses >= MEM_BYTES are errors
- CNT_W, 16 — width of each access counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 word, 01 half, 10 byte, 11 illegal
- req_unsigned  in  1  zero-extend load (half/byte only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle response strobe
- resp_err  out  1  misaligned, illegal size or out-of-range; qualified by resp_valid
- resp_rdata  out  32  load result
- MemR  out  1  memory read enable
- MemWr  out  1  memory write enable
- MemWrBits  out  2  00 sw, 01 sh, 10 sb
- MemRBits  out  3  000 lw, 001 lhu, 010 lh, 011 lbu, 100 lb
- MemAddr  out  32  byte address to memory
- MemWData  out  32  store data to memory
- MemRData  in  32  combinational read data from memory
- cnt_load, cnt_store, cnt_err  out  CNT_W each  access counters

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE
  - req_ready = 1.
  - On req_valid, latch store, size, unsigned, addr and wdata.
  - Error check: req_size == 11; half with addr[0] = 1; word with addr[1:0] != 0; addr >= MEM_BYTES.
  - Error → RESP with resp_err = 1, no memory strobe, cnt_err += 1.
  - No error → ACCESS.
- ACCESS
  - Exactly one cycle; MemAddr = latched addr.
  - Store: MemWr = 1 and MemWrBits = size code. MemWData = latched wdata unchanged; the memory performs byte-lane steering. cnt_store += 1.
  - Load: MemR = 1 and MemRBits from size/unsigned:
    - word → 000, regardless of unsigned
    - half → 001 if unsigned, 010 if signed
    - byte → 011 if unsigned, 100 if signed
  - Load: MemRData is captured into resp_rdata at the end of the cycle; cnt_load += 1.
  - Next state RESP.
- RESP
  - resp_valid = 1 for exactly one cycle, then IDLE.
  - req_ready = 0, so no back-to-back accept.
- resp_rdata:
  - load success: captured MemRData
  - store success: 0
  - error: 0
  - holds its value until the next response.
- Memory outputs are zero outside ACCESS: MemR, MemWr, MemWrBits, MemRBits, MemAddr, MemWData.
- MemR and MemWr are never high together.
- MemWr and MemR are gated by ~rst. A store whose ACCESS cycle coincides with rst must not write memory.
- Counters wrap modulo 2^CNT_W.
- Reset values:
  - state = IDLE; req_ready = 1 after reset.
  - resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - All counters 0; all memory outputs 0.

## Timing
- Request accepted at edge N (req_valid & req_ready).
- Valid access:
  - ACCESS occupies cycle N..N+1.
  - resp_valid is high in cycle N+1..N+2.
  - Throughput: one request per 3 cycles.
- Error: resp_valid is high in cycle N..N+1; throughput one per 2 cycles.
- req_valid while req_ready = 0 is ignored; the requester holds it.
- rst in any state: next edge → IDLE with all reset values.
  - A pending response is dropped.
  - Counter updates in that cycle are discarded.

## Test plan
- Store then load word:
  - Store word 0xDEADBEEF to addr 0x10. MemWr is high for exactly 1 cycle with MemWrBits = 00.
  - Then load word from 0x10. resp_rdata = 0xDEADBEEF two cycles after accept; cnt_store = 1, cnt_load = 1.
- Byte and half lanes:
  - Store byte 0x80 to 0x23, then load byte signed from 0x23 → resp_rdata = 0xFFFFFF80.
  - Load byte unsigned from 0x23 → 0x00000080.
  - Store half 0x8001 to 0x22, then load half signed from 0x22 → 0xFFFF8001.
- Errors:
  - Load word from 0x12 → resp_err = 1 one cycle after accept, MemR never high.
  - Store half to 0x21 → resp_err = 1, MemWr never high.
  - Load word from 0x800 (MEM_BYTES = 2048) → error.
  - req_size = 11 → error.
  - cnt_err = 4 after these four requests.
- Handshake: hold req_valid high continuously with alternating valid requests → req_ready high only in IDLE, accepts spaced exactly 3 cycles, one resp_valid per accept.
- Reset mid-access: assert rst during the ACCESS cycle of a store to 0x40 → MemWr stays 0, memory at 0x40 is unchanged on a later load, resp_valid never fires, and all counters are 0.
